// File: rtl/axi_lite_param_loader.sv
// AXI4-Lite master that writes a parallel parameter vector into NUM_REGS consecutive registers.
// Define PARAM_LOADER_VERIFY_EN to read back and compare every word after it is written.
module axi_lite_param_loader #(
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    start,
    input  logic [32*NUM_REGS-1:0]  params_in,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [3:0]              err_index,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [31:0]             M_AXI_WDATA,
    output logic [3:0]              M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]              M_AXI_ARPROT,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [31:0]             M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    output logic [2:0]              dbg_state
);

    // Every channel obeys AXI valid/ready: a transfer happens on a cycle where VALID and READY
    // are both high; VALID, address and data stay constant from assertion until that cycle.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WRESP = 3'd2,
        S_FIN   = 3'd3
`ifdef PARAM_LOADER_VERIFY_EN
        ,
        S_RD    = 3'd4,
        S_RDATA = 3'd5
`endif
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [3:0]            LAST_I = 4'(NUM_REGS - 1);

    state_t                  r_state;
    logic [3:0]              r_index;
    logic [32*NUM_REGS-1:0]  r_shadow;
    logic                    r_issued;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_error;
    logic [3:0]              r_err_index;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_awvalid;
    logic [31:0]             r_wdata;
    logic                    r_wvalid;
    logic                    r_bready;

    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [31:0]             w_word;
    logic                    w_last;
    logic                    w_aw_ok;
    logic                    w_w_ok;

    assign w_addr  = BASE_A + ADDR_WIDTH'({r_index, 2'b00});
    assign w_word  = r_shadow[32*r_index +: 32];
    assign w_last  = (r_index == LAST_I);
    // A channel counts as finished if it completed earlier or completes this cycle.
    assign w_aw_ok = r_aw_done | (r_awvalid & M_AXI_AWREADY);
    assign w_w_ok  = r_w_done  | (r_wvalid  & M_AXI_WREADY);

`ifdef PARAM_LOADER_VERIFY_EN
    logic [ADDR_WIDTH-1:0]   r_araddr;
    logic                    r_arvalid;
    logic                    r_rready;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= S_IDLE;
            r_index     <= '0;
            r_shadow    <= '0;
            r_issued    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
`ifdef PARAM_LOADER_VERIFY_EN
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shadow    <= params_in;
                        r_error     <= 1'b0;
                        r_err_index <= '0;
                        r_index     <= '0;
                        r_issued    <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_WR;
                    end
                end
                S_WR: begin
                    if (!r_issued) begin
                        r_awaddr  <= w_addr;
                        r_wdata   <= w_word;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_issued  <= 1'b1;
                    end else begin
                        if (r_awvalid && M_AXI_AWREADY) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (r_wvalid && M_AXI_WREADY) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if (w_aw_ok && w_w_ok) begin
                            r_issued <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready <= 1'b0;
                        if (M_AXI_BRESP != 2'b00) begin
                            r_error     <= 1'b1;
                            r_err_index <= r_index;
                            r_state     <= S_FIN;
                        end else begin
`ifdef PARAM_LOADER_VERIFY_EN
                            r_state <= S_RD;
`else
                            if (w_last) begin
                                r_state <= S_FIN;
                            end else begin
                                r_index <= r_index + 4'd1;
                                r_state <= S_WR;
                            end
`endif
                        end
                    end
                end
`ifdef PARAM_LOADER_VERIFY_EN
                S_RD: begin
                    if (!r_issued) begin
                        r_araddr  <= w_addr;
                        r_arvalid <= 1'b1;
                        r_issued  <= 1'b1;
                    end else if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_issued  <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready <= 1'b0;
                        if (M_AXI_RRESP != 2'b00 || M_AXI_RDATA != w_word) begin
                            r_error     <= 1'b1;
                            r_err_index <= r_index;
                            r_state     <= S_FIN;
                        end else if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_index <= r_index + 4'd1;
                            r_state <= S_WR;
                        end
                    end
                end
`endif
                S_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign err_index     = r_err_index;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARPROT  = 3'b000;
    assign dbg_state     = r_state;

`ifdef PARAM_LOADER_VERIFY_EN
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;
`else
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;
    logic w_unused_rd;
    assign w_unused_rd = &{1'b0, M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

endmodule

// File: tb/tb_axi_lite_param_loader.sv
// Directed bench for axi_lite_param_loader with a small AXI4-Lite slave model.
// Read-back checks are included when PARAM_LOADER_VERIFY_EN is defined.
module tb_axi_lite_param_loader;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] params_in = '0;
  logic         busy, done, error;
  logic [3:0]   err_index;
  logic [3:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot, dbg_state;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;

  always #5 clk = ~clk;

  axi_lite_param_loader dut (
    .ACLK(clk), .ARESETN(rst_n), .start(start), .params_in(params_in),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .dbg_state(dbg_state)
  );

  // slave model
  int          aw_delay = 0;
  int          err_waddr = -1;
  int          bad_raddr = -1;
  int          aw_wait;
  logic        got_aw, got_w;
  logic [3:0]  lat_addr, cur_addr;
  logic [31:0] lat_data, cur_data;
  logic [31:0] mem [4];
  logic        aw_hs, w_hs;
  logic [63:0] wr_q[$];
  logic [63:0] exp_q[$];
  logic [3:0]  rd_q[$];

  assign awready  = awvalid && (aw_wait >= aw_delay);
  assign wready   = 1'b1;
  assign arready  = 1'b1;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign cur_addr = got_aw ? lat_addr : awaddr;
  assign cur_data = got_w ? lat_data : wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00; aw_wait <= 0;
      lat_addr <= '0; lat_data <= '0;
    end else begin
      if (aw_hs) aw_wait <= 0;
      else if (awvalid) aw_wait <= aw_wait + 1;
      if (aw_hs) lat_addr <= awaddr;
      if (w_hs) lat_data <= wdata;
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        got_aw <= 1'b0;
        got_w  <= 1'b0;
        bvalid <= 1'b1;
        bresp  <= (int'(cur_addr) == err_waddr) ? 2'b10 : 2'b00;
        mem[cur_addr[3:2]] <= cur_data;
        wr_q.push_back({28'd0, cur_addr, cur_data});
      end else begin
        got_aw <= got_aw | aw_hs;
        got_w  <= got_w | w_hs;
        if (bvalid && bready) bvalid <= 1'b0;
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= (int'(araddr) == bad_raddr) ? 32'hDEADBEEF : mem[araddr[3:2]];
        rd_q.push_back(araddr);
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  int done_cnt = 0;
  int b_cnt = 0;
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (bvalid && bready) b_cnt++;
  end

  // scoreboard
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic [31:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  task automatic clear_logs();
    wr_q.delete(); rd_q.delete(); exp_q.delete();
    done_cnt = 0; b_cnt = 0;
  endtask

  task automatic start_seq(input logic [127:0] p);
    @(negedge clk);
    params_in = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 64'(wr_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
  endtask

  localparam logic [127:0] P1 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [127:0] P2 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
`ifdef PARAM_LOADER_VERIFY_EN
  localparam int LAT_FULL = 25;
`else
  localparam int LAT_FULL = 13;
`endif

  initial begin
    int cyc;
    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_err_index", 64'(err_index), 64'd0);
    check("rst_awvalid", 64'(awvalid), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_bready", 64'(bready), 64'd0);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_awaddr", 64'(awaddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_wstrb", 64'(wstrb), 64'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero-wait OKAY slave, full sequence
    clear_logs();
    exp_q = '{ent(32'h0, 32'd1), ent(32'h4, 32'd2), ent(32'h8, 32'd3), ent(32'hC, 32'd4)};
    start_seq(P1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done(cyc);
    check("t1_latency", 64'(cyc), 64'(LAT_FULL));
    repeat (5) @(negedge clk);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_error", 64'(error), 64'd0);
    check("t1_b_cnt", 64'(b_cnt), 64'd4);
    check_writes("t1");
`ifdef PARAM_LOADER_VERIFY_EN
    check("t1_rd_count", 64'(rd_q.size()), 64'd4);
    for (int i = 0; i < rd_q.size() && i < 4; i++)
      check($sformatf("t1_rd%0d", i), 64'(rd_q[i]), 64'(4 * i));
`endif

    // 2: AWREADY delayed 3 cycles, WREADY immediate
    clear_logs();
    aw_delay = 3;
    exp_q = '{ent(32'h0, 32'h11111111), ent(32'h4, 32'h22222222),
              ent(32'h8, 32'h33333333), ent(32'hC, 32'h44444444)};
    start_seq(P2);
    check("t2_awvalid_c0", 64'(awvalid), 64'd0);
    @(negedge clk);
    check("t2_wvalid_c1", 64'(wvalid), 64'd1);
    check("t2_wdata_c1", 64'(wdata), 64'h11111111);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) @(negedge clk);
      check($sformatf("t2_awvalid_c%0d", c), 64'(awvalid), 64'd1);
      check($sformatf("t2_awaddr_c%0d", c), 64'(awaddr), 64'd0);
      if (c == 2) check("t2_wvalid_c2", 64'(wvalid), 64'd0);
    end
    @(negedge clk);
    check("t2_awvalid_c5", 64'(awvalid), 64'd0);
    wait_done(cyc);
    repeat (5) @(negedge clk);
    check("t2_b_cnt", 64'(b_cnt), 64'd4);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_error", 64'(error), 64'd0);
    check_writes("t2");
    aw_delay = 0;

    // 3: SLVERR on the write to 0x8
    clear_logs();
    err_waddr = 8;
    exp_q = '{ent(32'h0, 32'd1), ent(32'h4, 32'd2), ent(32'h8, 32'd3)};
    start_seq(P1);
    wait_done(cyc);
    repeat (8) @(negedge clk);
    check("t3_error", 64'(error), 64'd1);
    check("t3_err_index", 64'(err_index), 64'd2);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);
    check("t3_b_cnt", 64'(b_cnt), 64'd3);
    check_writes("t3");
    err_waddr = -1;

    // 4: restart while busy and params_in changed mid-sequence
    clear_logs();
    exp_q = '{ent(32'h0, 32'd1), ent(32'h4, 32'd2), ent(32'h8, 32'd3), ent(32'hC, 32'd4)};
    start_seq(P1);
    repeat (4) @(negedge clk);
    params_in = {4{32'hFFFF0000}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    repeat (20) @(negedge clk);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);
    check("t4_busy", 64'(busy), 64'd0);
    check("t4_error_cleared", 64'(error), 64'd0);
    check_writes("t4");

    // 5: reset while AWVALID is high, then a clean run
    clear_logs();
    start_seq(P1);
    @(negedge clk);
    check("t5_awvalid_pre", 64'(awvalid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_awvalid_rst", 64'(awvalid), 64'd0);
    check("t5_wvalid_rst", 64'(wvalid), 64'd0);
    check("t5_busy_rst", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
    exp_q = '{ent(32'h0, 32'd1), ent(32'h4, 32'd2), ent(32'h8, 32'd3), ent(32'hC, 32'd4)};
    start_seq(P1);
    wait_done(cyc);
    check("t5_latency", 64'(cyc), 64'(LAT_FULL));
    repeat (5) @(negedge clk);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);
    check("t5_error", 64'(error), 64'd0);
    check_writes("t5");

`ifdef PARAM_LOADER_VERIFY_EN
    // 6: read-back of 0x4 returns a wrong value
    clear_logs();
    bad_raddr = 4;
    exp_q = '{ent(32'h0, 32'd1), ent(32'h4, 32'd2)};
    start_seq(P1);
    wait_done(cyc);
    repeat (8) @(negedge clk);
    check("t6_error", 64'(error), 64'd1);
    check("t6_err_index", 64'(err_index), 64'd1);
    check("t6_done_cnt", 64'(done_cnt), 64'd1);
    check("t6_rd_count", 64'(rd_q.size()), 64'd2);
    check_writes("t6");
    bad_raddr = -1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
